// File: rtl/simproc_pkg.sv
// Shared debug-port definitions for the simproc core: host command opcodes,
// controller states and STATUS byte layout (also used by the host bridge).
package simproc_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_MEM_WR = 3'd1,
    OP_MEM_RD = 3'd2,
    OP_SET_PC = 3'd3,
    OP_RUN    = 3'd4,
    OP_STOP   = 3'd5,
    OP_STATUS = 3'd6,
    OP_ILL    = 3'd7
  } dbg_op_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HOSTMEM = 2'd1,
    S_START   = 2'd2,
    S_RUN     = 2'd3
  } dbg_state_t;

  localparam int STAT_RUNNING_BIT   = 7;
  localparam int STAT_STOP_PEND_BIT = 6;

  function automatic logic [7:0] status_byte(input logic run, input logic stop_pend);
    logic [7:0] b;
    b = '0;
    b[STAT_RUNNING_BIT]   = run;
    b[STAT_STOP_PEND_BIT] = stop_pend;
    return b;
  endfunction

endpackage

// File: rtl/simproc_mem_mux.sv
// Single 8-bit memory port select: core while running, host during a host
// access cycle, otherwise the port is parked with all-zero request lines.
module simproc_mem_mux (
  input  logic       host_sel,
  input  logic       core_sel,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_din,
  input  logic       host_we,
  input  logic [7:0] core_addr,
  input  logic [7:0] core_din,
  input  logic       core_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_din,
  output logic       mem_we
);

  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_we   = 1'b0;
    if (core_sel) begin
      mem_addr = core_addr;
      mem_din  = core_din;
      mem_we   = core_we;
    end else if (host_sel) begin
      mem_addr = host_addr;
      mem_din  = host_din;
      mem_we   = host_we;
    end
  end

endmodule

// File: rtl/simproc_dbg_ctrl.sv
// Host-side debug/run controller for simproc: decodes host commands, sequences
// the core's pc_set/run/done port and arbitrates the shared memory port.
module simproc_dbg_ctrl
  import simproc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [7:0]       cmd_addr,
  input  logic [7:0]       cmd_data,
  output logic             rsp_valid,
  output logic [7:0]       rsp_data,
  output logic [CNT_W-1:0] ret_cnt,
  output logic             running,
  output logic [7:0]       core_pc_val,
  output logic             core_pc_wr,
  output logic             core_run,
  input  logic             core_halt,
  input  logic             core_done,
  input  logic [7:0]       core_mem_addr,
  input  logic [7:0]       core_mem_din,
  input  logic             core_mem_we,
  output logic [7:0]       core_mem_dout,
  output logic [7:0]       mem_addr,
  output logic [7:0]       mem_din,
  output logic             mem_we,
  input  logic [7:0]       mem_dout
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  dbg_state_t state, state_nxt;
  dbg_op_t    op;
  logic [7:0] count, ran;
  logic [7:0] hm_addr, hm_din;
  logic       hm_wr;
  logic       stop_pend;
  logic       accept, stop_now, last_done;
  logic       unused_halt;

  // Termination is tracked from done pulses; the halt level is not needed here.
  assign unused_halt = core_halt;

  assign op            = dbg_op_t'(cmd_op);
  assign core_mem_dout = mem_dout;

  always_comb begin
    cmd_ready = rst && ((state == S_IDLE) ||
                        ((state == S_RUN) && ((op == OP_STOP) || (op == OP_STATUS))));
    accept    = cmd_valid && cmd_ready;
    stop_now  = accept && (state == S_RUN) && (op == OP_STOP);
    // A STOP arriving with the done pulse must end the run on that instruction.
    last_done = (state == S_RUN) && core_done &&
                (stop_pend || stop_now || ((count != 8'd0) && (ran == count - 8'd1)));
    running   = (state == S_RUN);
    core_run  = (state == S_START) || ((state == S_RUN) && !last_done);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_MEM_WR, OP_MEM_RD: state_nxt = S_HOSTMEM;
            OP_RUN:               state_nxt = S_START;
            default:              state_nxt = S_IDLE;
          endcase
        end
      end
      S_HOSTMEM: state_nxt = S_IDLE;
      S_START:   state_nxt = S_RUN;
      S_RUN:     if (last_done) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      core_pc_wr  <= 1'b0;
      core_pc_val <= '0;
      ret_cnt     <= '0;
      count       <= '0;
      ran         <= '0;
      stop_pend   <= 1'b0;
      hm_wr       <= 1'b0;
    end else begin
      state      <= state_nxt;
      rsp_valid  <= 1'b0;
      core_pc_wr <= 1'b0;
      if (accept) begin
        case (op)
          OP_MEM_WR, OP_MEM_RD: hm_wr <= (op == OP_MEM_WR);
          OP_SET_PC: begin
            core_pc_val <= cmd_data;
            core_pc_wr  <= 1'b1;
          end
          OP_RUN: begin
            count <= cmd_data;
            ran   <= '0;
          end
          OP_STOP: if (state == S_RUN) stop_pend <= 1'b1;
          OP_STATUS: begin
            rsp_valid <= 1'b1;
            rsp_data  <= status_byte(running, stop_pend);
          end
          default: ;
        endcase
      end
      if ((state == S_HOSTMEM) && !hm_wr) begin
        rsp_valid <= 1'b1;
        rsp_data  <= mem_dout;
      end
      if (running && core_done) begin
        ret_cnt <= ret_cnt + CNT_ONE;
        ran     <= ran + 8'd1;
      end
      if (last_done) begin
        stop_pend <= 1'b0;
        ran       <= '0;
      end
    end
  end

  // Host access operands are pure data and need no reset.
  always_ff @(posedge clk) begin
    if (accept && ((op == OP_MEM_WR) || (op == OP_MEM_RD))) begin
      hm_addr <= cmd_addr;
      hm_din  <= cmd_data;
    end
  end

  simproc_mem_mux u_mem_mux (
    .host_sel  (state == S_HOSTMEM),
    .core_sel  (running),
    .host_addr (hm_addr),
    .host_din  (hm_din),
    .host_we   (hm_wr),
    .core_addr (core_mem_addr),
    .core_din  (core_mem_din),
    .core_we   (core_mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_we    (mem_we)
  );

endmodule
